apb_cfg_slave: RTL
==================

APB_CFG_SLAVE -- requirements
Module: apb_cfg_slave

Interface
REQ-001 SHALL have parameter REG_ADDRWIDTH, default 8, APB address width (byte addresses).
REQ-002 SHALL have parameter REG_DATAWIDTH, default 32, APB data width.
REQ-003 SHALL have parameter AWIDTH, default 10, matrix BRAM address width.
REQ-004 SHALL have parameter MAT_MUL_SIZE, default 4, systolic array dimension (mask width).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 resetn  in  1  synchronous reset, active low.
REQ-008 PADDR  in  REG_ADDRWIDTH  APB address.
REQ-009 PWRITE  in  1  1=write, 0=read.
REQ-010 PSEL  in  1  slave select.
REQ-011 PENABLE  in  1  APB access-phase strobe.
REQ-012 PWDATA  in  REG_DATAWIDTH  write data.
REQ-013 PRDATA  out  REG_DATAWIDTH  registered read data, held until next read.
REQ-014 PREADY  out  1  registered one-cycle transfer-complete strobe.
REQ-015 done_tpu  in  1  one-cycle pulse from matmul controller: operation finished.
REQ-016 start_tpu  out  1  one-cycle start pulse to matmul controller.
REQ-017 busy  out  1  operation in flight.
REQ-018 accum_en  out  1  accumulate into existing C contents.
REQ-019 address_mat_a / address_mat_b / address_mat_c  out  AWIDTH each  BRAM base addresses.
REQ-020 validity_mask_a / validity_mask_b  out  MAT_MUL_SIZE each  row/column valid masks.

Function
REQ-021 SHALL implement APB FSM IDLE->SETUP (PSEL & !PENABLE), SETUP->ACCESS (PSEL & PENABLE), ACCESS->IDLE unconditionally; SETUP with PSEL=0 -> IDLE.
REQ-022 On the SETUP->ACCESS edge SHALL commit the write or capture PRDATA, and assert PREADY for exactly the ACCESS cycle (zero wait states).
REQ-023 Register map: 0x00 CTRL (bit0 start W1 self-clearing, bit1 accum_en RW); 0x04 STATUS (bit0 done sticky W1C, bit1 busy RO); 0x08/0x0C/0x10 ADDR_A/B/C RW [AWIDTH-1:0]; 0x14 MASK (bits[MAT_MUL_SIZE-1:0] mask_a, bits[MAT_MUL_SIZE+15:16] mask_b) RW; 0x18 CYCLES RO.
REQ-024 Unused register bits SHALL read 0; unmapped addresses SHALL read 0 and ignore writes.
REQ-025 Write CTRL bit0=1 while busy=0 SHALL pulse start_tpu on the cycle after commit, set busy, clear done and CYCLES in that same cycle.
REQ-026 Write CTRL bit0=1 while busy=1 SHALL be ignored for start; bit1 SHALL still update.
REQ-027 done_tpu=1 while busy=1 SHALL clear busy and set done next cycle; done_tpu while busy=0 SHALL be ignored.
REQ-028 Simultaneous done_tpu and STATUS W1C in one cycle: set wins (done=1).
REQ-029 CYCLES SHALL increment by 1 each cycle busy=1, saturate at all-ones, hold when idle.
REQ-030 Config outputs SHALL be driven directly from registers and change the cycle after commit.

Reset
REQ-031 resetn=0 at a clock edge SHALL force FSM IDLE, PRDATA=0, PREADY=0, start_tpu=0, busy=0, done=0, accum_en=0, all addresses 0, all masks all-ones, CYCLES=0.
REQ-032 Reset mid-transfer or mid-operation SHALL abort it; no write committed, no start pulse emitted after reset.

Verification
REQ-033 Write 0x08<-0x123 then read 0x08 -> PRDATA=0x00000123 at negedge after access; address_mat_a=0x123.
REQ-034 Write 0x00<-0x1 -> start_tpu high exactly 1 cycle, busy=1; read 0x04 -> 0x2; drive done_tpu after 20 cycles -> busy=0, read 0x04 -> 0x1, read 0x18 -> 20.
REQ-035 Second start write while busy -> no start_tpu pulse; write 0x04<-0x1 with done=1 -> read 0x04 -> 0x0.
REQ-036 Write 0x14<-0x0003_0005 -> mask_a=0x5, mask_b=0x3; read 0x40 -> 0; write 0x40<-0xFFFF_FFFF -> no register change.
REQ-037 Assert resetn=0 during SETUP of a write to 0x0C and while busy -> after release address_mat_b=0, busy=0, PREADY=0, masks=0xF.

Source files
------------

// File: rtl/apb_cfg_slave.sv
// APB configuration/status slave for the matmul (TPU) controller.
// Holds BRAM base addresses, validity masks and the accumulate flag,
// launches operations with a one-cycle start pulse and tracks busy/done
// plus a saturating busy-cycle counter.
module apb_cfg_slave #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int AWIDTH        = 10,
  parameter int MAT_MUL_SIZE  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  input  logic                     done_tpu,
  output logic                     start_tpu,
  output logic                     busy,
  output logic                     accum_en,
  output logic [AWIDTH-1:0]        address_mat_a,
  output logic [AWIDTH-1:0]        address_mat_b,
  output logic [AWIDTH-1:0]        address_mat_c,
  output logic [MAT_MUL_SIZE-1:0]  validity_mask_a,
  output logic [MAT_MUL_SIZE-1:0]  validity_mask_b
);

  // State table
  //   ST_IDLE   | no transfer in progress
  //   ST_SETUP  | PSEL seen without PENABLE, waiting for access phase
  //   ST_ACCESS | transfer committed, PREADY high for this one cycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int MASK_B_LSB = 16;

  localparam logic [REG_ADDRWIDTH-1:0] ADDR_CTRL   = REG_ADDRWIDTH'(8'h00);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_STATUS = REG_ADDRWIDTH'(8'h04);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_A      = REG_ADDRWIDTH'(8'h08);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_B      = REG_ADDRWIDTH'(8'h0C);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_C      = REG_ADDRWIDTH'(8'h10);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_MASK   = REG_ADDRWIDTH'(8'h14);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_CYCLES = REG_ADDRWIDTH'(8'h18);

  apb_state_t                 state_q, state_d;
  logic [REG_DATAWIDTH-1:0]   prdata_q, prdata_d;
  logic                       pready_q, pready_d;
  logic                       start_tpu_q, start_tpu_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       accum_en_q, accum_en_d;
  logic [AWIDTH-1:0]          addr_a_q, addr_a_d;
  logic [AWIDTH-1:0]          addr_b_q, addr_b_d;
  logic [AWIDTH-1:0]          addr_c_q, addr_c_d;
  logic [MAT_MUL_SIZE-1:0]    mask_a_q, mask_a_d;
  logic [MAT_MUL_SIZE-1:0]    mask_b_q, mask_b_d;
  logic [REG_DATAWIDTH-1:0]   cycles_q, cycles_d;

  logic                       commit;
  logic                       wr_en;
  logic                       rd_en;
  logic                       sel_ctrl, sel_status, sel_a, sel_b, sel_c, sel_mask, sel_cycles;
  logic                       start_fire;
  logic                       done_fire;
  logic [REG_DATAWIDTH-1:0]   rd_val;

  // Upper PWDATA bits have no destination register.
  logic                       unused_pwdata;
  assign unused_pwdata = ^PWDATA;

  // Address decode: exact byte-address match, anything else is unmapped.
  always_comb begin
    sel_ctrl   = (PADDR == ADDR_CTRL);
    sel_status = (PADDR == ADDR_STATUS);
    sel_a      = (PADDR == ADDR_A);
    sel_b      = (PADDR == ADDR_B);
    sel_c      = (PADDR == ADDR_C);
    sel_mask   = (PADDR == ADDR_MASK);
    sel_cycles = (PADDR == ADDR_CYCLES);
  end

  // APB protocol next-state and the single commit strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (PSEL && !PENABLE) state_d = ST_SETUP;
      ST_SETUP: begin
        if (!PSEL)        state_d = ST_IDLE;
        else if (PENABLE) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    commit = (state_q == ST_SETUP) && PSEL && PENABLE;
    wr_en  = commit && PWRITE;
    rd_en  = commit && !PWRITE;
  end

  // Read mux; unused bits and unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    if (sel_ctrl) begin
      rd_val[1] = accum_en_q;
    end else if (sel_status) begin
      rd_val[0] = done_q;
      rd_val[1] = busy_q;
    end else if (sel_a) begin
      rd_val[AWIDTH-1:0] = addr_a_q;
    end else if (sel_b) begin
      rd_val[AWIDTH-1:0] = addr_b_q;
    end else if (sel_c) begin
      rd_val[AWIDTH-1:0] = addr_c_q;
    end else if (sel_mask) begin
      rd_val[MAT_MUL_SIZE-1:0]              = mask_a_q;
      rd_val[MASK_B_LSB +: MAT_MUL_SIZE]    = mask_b_q;
    end else if (sel_cycles) begin
      rd_val = cycles_q;
    end
  end

  // Register-file next values, operation launch/complete and cycle counter.
  always_comb begin
    start_fire  = wr_en && sel_ctrl && PWDATA[0] && !busy_q;
    done_fire   = done_tpu && busy_q;

    prdata_d    = rd_en ? rd_val : prdata_q;
    pready_d    = commit;
    start_tpu_d = start_fire;

    busy_d = busy_q;
    if (start_fire)     busy_d = 1'b1;
    else if (done_fire) busy_d = 1'b0;

    // A completing operation beats a same-cycle W1C so the event is not lost.
    done_d = done_q;
    if (done_fire)                             done_d = 1'b1;
    else if (start_fire)                       done_d = 1'b0;
    else if (wr_en && sel_status && PWDATA[0]) done_d = 1'b0;

    cycles_d = cycles_q;
    if (start_fire)                     cycles_d = '0;
    else if (busy_q && cycles_q != '1)  cycles_d = cycles_q + REG_DATAWIDTH'(1);

    accum_en_d = (wr_en && sel_ctrl) ? PWDATA[1] : accum_en_q;
    addr_a_d   = (wr_en && sel_a) ? PWDATA[AWIDTH-1:0] : addr_a_q;
    addr_b_d   = (wr_en && sel_b) ? PWDATA[AWIDTH-1:0] : addr_b_q;
    addr_c_d   = (wr_en && sel_c) ? PWDATA[AWIDTH-1:0] : addr_c_q;
    mask_a_d   = (wr_en && sel_mask) ? PWDATA[MAT_MUL_SIZE-1:0] : mask_a_q;
    mask_b_d   = (wr_en && sel_mask) ? PWDATA[MASK_B_LSB +: MAT_MUL_SIZE] : mask_b_q;
  end

  // All state updates; synchronous active-low reset aborts any transfer or operation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      start_tpu_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      accum_en_q  <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      mask_a_q    <= '1;
      mask_b_q    <= '1;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      start_tpu_q <= start_tpu_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      accum_en_q  <= accum_en_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      mask_a_q    <= mask_a_d;
      mask_b_q    <= mask_b_d;
      cycles_q    <= cycles_d;
    end
  end

  assign PRDATA          = prdata_q;
  assign PREADY          = pready_q;
  assign start_tpu       = start_tpu_q;
  assign busy            = busy_q;
  assign accum_en        = accum_en_q;
  assign address_mat_a   = addr_a_q;
  assign address_mat_b   = addr_b_q;
  assign address_mat_c   = addr_c_q;
  assign validity_mask_a = mask_a_q;
  assign validity_mask_b = mask_b_q;

endmodule
